// File: rtl/ram_arb_pkg.sv
// Shared definitions for the microram port arbiter and the wrappers around it.
//   - arbiter state encoding (IDLE / OWN0 / OWN1)
//   - owner output encoding (none / port 0 / port 1)
//   - default RAM geometry (512 x 8)
package ram_arb_pkg;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0   = 2'b01;
  localparam logic [1:0] OWNER_P1   = 2'b10;

  function automatic logic [1:0] owner_of(state_t s);
    case (s)
      OWN0:    owner_of = OWNER_P0;
      OWN1:    owner_of = OWNER_P1;
      default: owner_of = OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester port of the microram arbiter.
//   master : the requester (drives req/we/addr/wdata, sees gnt/rvalid/rdata)
//   slave  : the arbiter side
// req is held with we/addr/wdata stable until gnt is seen high.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rd_valid_pipe.sv
// Read-valid delay line: a 1-bit shift register LAT stages deep.
//   clk, reset : clock and synchronous active-high clear
//   vld_in     : read grant issued this cycle
//   vld_out    : read data valid, LAT cycles later
// The output is gated by reset so a read already in flight when reset
// rises never reports valid.
module rd_valid_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic vld_in,
  output logic vld_out
);
  logic [LAT-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= LAT'({vld_pipe, vld_in});
  end

  assign vld_out = vld_pipe[LAT-1] & ~reset;
endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the single-port 512x8 microram.
//   clk, reset        : clock, synchronous active-high reset
//   p0, p1            : requester ports (p0 = CPU memory phase, p1 = loader/debug)
//   ram_addr/din/we   : microram address, write data and write enable
//   ram_dout          : microram read data (synchronous, RD_LAT cycles)
//   owner             : registered owner, 00 idle / 01 port 0 / 10 port 1
// Grants are combinational from state and req so an allowed request is
// served in the cycle it is raised. Ownership is round-robin with at most
// MAX_BURST consecutive grants while the other port is waiting.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   p0,
  ram_port_arbiter_if.slave   p1,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_din,
  output logic                ram_we,
  input  logic [DW-1:0]       ram_dout,
  output logic [1:0]          owner
);
  localparam int             BW   = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  MAXB = BW'(MAX_BURST);
  localparam logic [BW-1:0]  ONE  = BW'(1);

  state_t        state, state_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          last_served, last_nxt;
  logic          g0, g1;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;

  always_comb begin
    g0        = 1'b0;
    g1        = 1'b0;
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        // tie goes to the port that was not served last
        if (p0.req && (!p1.req || last_served)) begin
          g0 = 1'b1; state_nxt = OWN0; burst_nxt = ONE;
        end else if (p1.req) begin
          g1 = 1'b1; state_nxt = OWN1; burst_nxt = ONE;
        end
      end
      OWN0: begin
        if (p0.req && (burst_cnt < MAXB || !p1.req)) begin
          g0 = 1'b1;
          burst_nxt = (burst_cnt < MAXB) ? burst_cnt + ONE : burst_cnt;
        end else if (p1.req) begin
          // owner dropped or burst exhausted: hand over without a bubble
          g1 = 1'b1; state_nxt = OWN1; burst_nxt = ONE;
        end else begin
          state_nxt = IDLE; burst_nxt = '0;
        end
      end
      OWN1: begin
        if (p1.req && (burst_cnt < MAXB || !p0.req)) begin
          g1 = 1'b1;
          burst_nxt = (burst_cnt < MAXB) ? burst_cnt + ONE : burst_cnt;
        end else if (p0.req) begin
          g0 = 1'b1; state_nxt = OWN0; burst_nxt = ONE;
        end else begin
          state_nxt = IDLE; burst_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE; burst_nxt = '0;
      end
    endcase
    if (reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  assign last_nxt = g0 ? 1'b0 : (g1 ? 1'b1 : last_served);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state       <= state_nxt;
      burst_cnt   <= burst_nxt;
      last_served <= last_nxt;
      if (g0 || g1) begin
        addr_q <= ram_addr;
        din_q  <= ram_din;
      end
    end
  end

  // RAM pins follow the granted port; with no grant they hold the last
  // issued address/data so the bus does not toggle needlessly.
  assign ram_addr = g0 ? p0.addr  : (g1 ? p1.addr  : addr_q);
  assign ram_din  = g0 ? p0.wdata : (g1 ? p1.wdata : din_q);
  assign ram_we   = (g0 & p0.we) | (g1 & p1.we);

  assign p0.gnt   = g0;
  assign p1.gnt   = g1;
  assign p0.rdata = ram_dout;
  assign p1.rdata = ram_dout;
  assign owner    = owner_of(state);

  rd_valid_pipe #(.LAT(RD_LAT)) u_rv0 (
    .clk(clk), .reset(reset), .vld_in(g0 & ~p0.we), .vld_out(p0.rvalid)
  );

  rd_valid_pipe #(.LAT(RD_LAT)) u_rv1 (
    .clk(clk), .reset(reset), .vld_in(g1 & ~p1.we), .vld_out(p1.rvalid)
  );
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic.
// A per-cycle reference model predicts grants from grant history and the
// RAM contents from issued writes; read expectations go into per-port
// queues that a separate monitor drains on rvalid.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW   = 9;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_we;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) p0 ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) p1 ();

  ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .p0(p0), .p1(p1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .owner(owner)
  );

  // microram stand-in: synchronous read, write on the clock edge
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] q0[$], q1[$];
  int            prev = -1;   // port granted last cycle, -1 if none
  int            run  = 0;    // consecutive-cycle grants to prev
  int            last = 1;    // port served most recently
  int            e;
  logic [AW-1:0] la = '0;
  logic [DW-1:0] ld = '0;
  logic          s_we;
  logic [AW-1:0] s_a;
  logic [DW-1:0] s_d;
  logic [1:0]    eo;

  always @(negedge clk) if (chk_en) begin
    eo = (prev < 0) ? 2'b00 : ((prev == 0) ? 2'b01 : 2'b10);
    chk("owner", 32'(owner), 32'(eo));
    if (reset) begin
      chk("gnt0_rst", 32'(p0.gnt), 32'd0);
      chk("gnt1_rst", 32'(p1.gnt), 32'd0);
      chk("ram_we_rst", 32'(ram_we), 32'd0);
      prev = -1; run = 0; last = 1; la = '0; ld = '0;
      q0.delete(); q1.delete();
    end else begin
      if (p0.req && p1.req)
        e = (prev < 0) ? 1 - last : ((run < MAXB) ? prev : 1 - prev);
      else if (p0.req) e = 0;
      else if (p1.req) e = 1;
      else             e = -1;
      chk("gnt0", 32'(p0.gnt), 32'(e == 0));
      chk("gnt1", 32'(p1.gnt), 32'(e == 1));
      if (e < 0) begin
        chk("ram_we_idle", 32'(ram_we), 32'd0);
        chk("ram_addr_hold", 32'(ram_addr), 32'(la));
        chk("ram_din_hold", 32'(ram_din), 32'(ld));
        prev = -1; run = 0;
      end else begin
        s_we = (e == 0) ? p0.we    : p1.we;
        s_a  = (e == 0) ? p0.addr  : p1.addr;
        s_d  = (e == 0) ? p0.wdata : p1.wdata;
        chk("ram_we", 32'(ram_we), 32'(s_we));
        chk("ram_addr", 32'(ram_addr), 32'(s_a));
        chk("ram_din", 32'(ram_din), 32'(s_d));
        la = s_a; ld = s_d;
        if (s_we) ref_mem[s_a] = s_d;
        else if (e == 0) q0.push_back(ref_mem[s_a]);
        else q1.push_back(ref_mem[s_a]);
        run  = (e == prev) ? run + 1 : 1;
        last = e;
        prev = e;
      end
    end
  end

  // ---------------- read-return monitor ----------------
  always @(negedge clk) if (chk_en) begin
    if (reset) begin
      chk("rvalid0_rst", 32'(p0.rvalid), 32'd0);
      chk("rvalid1_rst", 32'(p1.rvalid), 32'd0);
    end else begin
      if (p0.rvalid) begin
        if (q0.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
        else chk("rdata0", 32'(p0.rdata), 32'(q0.pop_front()));
      end
      if (p1.rvalid) begin
        if (q1.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
        else chk("rdata1", 32'(p1.rdata), 32'(q1.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic g0s, g1s, r0s, r1s;

  task automatic cyc();
    @(negedge clk);
    g0s = p0.gnt; g1s = p1.gnt; r0s = p0.rvalid; r1s = p1.rvalid;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0.req = r; p0.we = w; p0.addr = a; p0.wdata = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1.req = r; p1.we = w; p1.addr = a; p1.wdata = d;
  endtask

  // waits for the port's grant; returns the number of cycles it took
  task automatic wait_gnt(input int p, output int k);
    for (k = 1; k <= 40; k++) begin
      cyc();
      if ((p == 0 && g0s) || (p == 1 && g1s)) return;
    end
    chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc();
    reset = 1'b0;
  endtask

  task automatic rnd_port(input int p);
    logic          r, w;
    logic [AW-1:0] a;
    int            s;
    r = ($urandom_range(0, 3) != 0);
    w = ($urandom_range(0, 2) == 0);
    s = $urandom_range(0, 8);
    a = (s == 8) ? 9'h1FF : AW'(s);
    if (p == 0) set0(r, w, a, DW'($urandom));
    else        set1(r, w, a, DW'($urandom));
  endtask

  initial begin
    int k;
    reset = 1'b1;
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    for (int i = 0; i < 512; i++) begin
      mem[i]     = DW'(i * 37 + 11);
      ref_mem[i] = DW'(i * 37 + 11);
    end
    mem[5] = 8'h3C; ref_mem[5] = 8'h3C;
    @(posedge clk); #1;
    chk_en = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // single read at 0x005
    set0(1, 0, 9'h005, 8'h00);
    wait_gnt(0, k);
    chk("t1_same_cycle", 32'(k), 32'd1);
    set0(0, 0, '0, '0);
    cyc();
    chk("t1_rvalid0", 32'(r0s), 32'd1);
    chk("t1_rvalid1", 32'(r1s), 32'd0);
    cyc();

    // continuous contention from IDLE after reset: 4/4/4 pattern
    do_reset(2);
    set0(1, 0, AW'($urandom_range(0, 511)), '0);
    set1(1, 0, AW'($urandom_range(0, 511)), '0);
    for (int c = 0; c < 12; c++) begin
      cyc();
      chk("t2_pattern", 32'({g0s, g1s}), ((c / 4) % 2 == 0) ? 32'd2 : 32'd1);
      if (g0s) p0.addr = AW'($urandom_range(0, 511));
      if (g1s) p1.addr = AW'($urandom_range(0, 511));
    end
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
    cyc(); cyc();

    // port 1 write 0x1FF, then port 0 reads it back
    set1(1, 1, 9'h1FF, 8'hA5);
    wait_gnt(1, k);
    set1(0, 0, '0, '0);
    set0(1, 0, 9'h1FF, 8'h00);
    wait_gnt(0, k);
    set0(0, 0, '0, '0);
    cyc();
    chk("t3_rvalid0", 32'(r0s), 32'd1);
    chk("t3_rvalid1", 32'(r1s), 32'd0);
    cyc();

    // owner 0 drops mid-burst while port 1 waits
    set0(1, 0, 9'h010, '0);
    wait_gnt(0, k);
    set0(1, 0, 9'h011, '0);
    set1(1, 0, 9'h020, '0);
    cyc();
    chk("t4_second_gnt0", 32'({g0s, g1s}), 32'd2);
    set0(0, 0, '0, '0);
    cyc();
    chk("t4_handover", 32'({g0s, g1s}), 32'd1);
    set1(0, 0, '0, '0);
    cyc(); cyc();

    // reset the cycle after a read grant squashes the return
    set0(1, 0, 9'h030, '0);
    wait_gnt(0, k);
    set0(0, 0, '0, '0);
    set1(1, 1, 9'h031, 8'h77);
    reset = 1'b1;
    cyc();
    chk("t5_rvalid0_squash", 32'(r0s), 32'd0);
    chk("t5_no_gnt", 32'({g0s, g1s}), 32'd0);
    cyc();
    set1(0, 0, '0, '0);
    reset = 1'b0;
    cyc();
    chk("t5_owner_idle", 32'(owner), 32'd0);

    // back-to-back reads on port 1
    for (int i = 0; i < 10; i++) begin
      set1(1, 0, AW'(9'h100 + i), '0);
      wait_gnt(1, k);
      chk("t6_b2b", 32'(k), 32'd1);
      if (i > 0) chk("t6_rvalid1", 32'(r1s), 32'd1);
    end
    set1(0, 0, '0, '0);
    cyc();
    chk("t6_rvalid1_last", 32'(r1s), 32'd1);
    cyc();

    // random traffic with occasional reset pulses
    for (int c = 0; c < 600; c++) begin
      if (!p0.req || g0s) rnd_port(0);
      if (!p1.req || g1s) rnd_port(1);
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;
    set0(0, 0, '0, '0); set1(0, 0, '0, '0);
    cyc(); cyc(); cyc();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
